avm_sample_ring_writer: RTL

- Avalon-MM write master that takes the 16-bit audio sample stream and stores it in on-chip RAM as a circular buffer.
- Packs two samples into each 32-bit word and issues single-word writes into a BUF_WORDS window starting at BASE_ADDR.
- Flags every buffer wrap so the Nios II software can process a completed block.
- Forms the writer end of the on-chip memory s1 slave path.

---
 rtl/avm_sample_ring_writer.sv | 117 +++++++++++
 1 files changed

// File: rtl/avm_sample_ring_writer.sv
// avm_sample_ring_writer: packs 16-bit audio samples into 32-bit words and writes them
// into a circular buffer in on-chip RAM through an Avalon-MM write master.
//
// Ports:
//   clk              system clock
//   reset_n          asynchronous active-low reset
//   enable           capture enable (level)
//   snk_data/valid   sample stream in; snk_ready out, sample taken on valid & ready
//   avm_address      word address = BASE_ADDR + wr_ptr
//   avm_byteenable   4'hF for a full word, 4'h3 for a flushed half word
//   avm_write        write request, held until accepted
//   avm_writedata    {newer sample, older sample}
//   avm_waitrequest  slave stall
//   wr_ptr           ring offset of the next word to be written
//   block_done       one-cycle pulse after the last ring word is accepted
//   busy             high in RUN or FLUSH
module avm_sample_ring_writer #(
    parameter int BASE_ADDR = 0,
    parameter int BUF_WORDS = 1024,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [15:0]       snk_data,
    input  logic              snk_valid,
    output logic              snk_ready,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              block_done,
    output logic              busy
);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BUF_WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t            state;
    logic              half_valid;
    logic [15:0]       half_data;
    logic              accept;
    logic              out_free;
    logic              take;
    logic [ADDR_W-1:0] ptr_inc;
    logic [ADDR_W-1:0] ptr_nxt;

    assign accept   = avm_write & ~avm_waitrequest;
    // Output register can take a new word this cycle: empty, or its word leaves now.
    assign out_free = ~avm_write | ~avm_waitrequest;
    assign snk_ready = (state == RUN) & (~half_valid | out_free);
    assign take     = snk_valid & snk_ready;
    assign ptr_inc  = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
    // Offset of the word loaded this cycle: the pending word (if any) is accepted first.
    assign ptr_nxt  = accept ? ptr_inc : wr_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            half_valid     <= 1'b0;
            half_data      <= '0;
            avm_address    <= '0;
            avm_byteenable <= '0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            wr_ptr         <= '0;
            block_done     <= 1'b0;
            busy           <= 1'b0;
        end else begin
            block_done <= 1'b0;
            if (accept) begin
                avm_write  <= 1'b0;
                wr_ptr     <= ptr_inc;
                block_done <= (wr_ptr == LAST);
            end
            case (state)
                IDLE: begin
                    if (enable) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        wr_ptr     <= '0;
                        half_valid <= 1'b0;
                    end
                end
                RUN: begin
                    if (take && !half_valid) begin
                        half_data  <= snk_data;
                        half_valid <= 1'b1;
                    end else if (take) begin
                        avm_writedata  <= {snk_data, half_data};
                        avm_byteenable <= 4'hF;
                        avm_address    <= BASE + ptr_nxt;
                        avm_write      <= 1'b1;
                        half_valid     <= 1'b0;
                    end
                    if (!enable) state <= FLUSH;
                end
                FLUSH: begin
                    if (out_free && half_valid) begin
                        avm_writedata  <= {16'h0000, half_data};
                        avm_byteenable <= 4'h3;
                        avm_address    <= BASE + ptr_nxt;
                        avm_write      <= 1'b1;
                        half_valid     <= 1'b0;
                    end else if (out_free) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
